// File: rtl/bit_step_feeder.sv
// rtl/bit_step_feeder.sv - synchronize and debounce a data switch and a step button into dInew/dSnew strobes
// Optional accepted-press counter port stepCount: define BIT_STEP_COUNT_EN.
module bit_step_feeder #(
    parameter int DEB_CYCLES = 250000,
    parameter int CNT_W      = 18
) (
    input  logic clk1,
    input  logic clear_n,
    input  logic dIraw,
    input  logic stepRaw,
    output logic dInew,
    output logic dSnew
`ifdef BIT_STEP_COUNT_EN
    ,
    output logic [7:0] stepCount
`endif
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {REL, PRESS_WAIT, HELD, REL_WAIT} step_state_t;

    logic             d_s1, d_s2;
    logic             s_s1, s_s2;
    logic [1:0]       sync_fill;
    logic             armed;
    logic             d_stable;
    logic [CNT_W-1:0] d_cnt;
    logic [CNT_W-1:0] s_cnt;
    step_state_t      state;

    // The synchronizers reset to 0, so a button held through reset would look like a
    // fresh press; presses are only armed once a real released sample has been seen.
    always_ff @(posedge clk1 or negedge clear_n) begin
        if (!clear_n) begin
            d_s1      <= 1'b0;
            d_s2      <= 1'b0;
            s_s1      <= 1'b0;
            s_s2      <= 1'b0;
            sync_fill <= 2'd0;
            armed     <= 1'b0;
        end else begin
            d_s1 <= dIraw;
            d_s2 <= d_s1;
            s_s1 <= stepRaw;
            s_s2 <= s_s1;
            if (sync_fill != 2'd2)
                sync_fill <= sync_fill + 2'd1;
            if (sync_fill == 2'd2 && !s_s2)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk1 or negedge clear_n) begin
        if (!clear_n) begin
            d_stable <= 1'b0;
            d_cnt    <= '0;
        end else if (d_s2 != d_stable) begin
            if (d_cnt == CNT_LAST) begin
                d_stable <= ~d_stable;
                d_cnt    <= '0;
            end else begin
                d_cnt <= d_cnt + CNT_ONE;
            end
        end else begin
            d_cnt <= '0;
        end
    end

    always_ff @(posedge clk1 or negedge clear_n) begin
        if (!clear_n) begin
            state     <= REL;
            s_cnt     <= '0;
            dInew     <= 1'b0;
            dSnew     <= 1'b0;
`ifdef BIT_STEP_COUNT_EN
            stepCount <= 8'd0;
`endif
        end else begin
            dSnew <= 1'b0;
            case (state)
                REL: begin
                    if (s_s2 && armed) begin
                        state <= PRESS_WAIT;
                        s_cnt <= CNT_ONE;
                    end else begin
                        s_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s_s2) begin
                        state <= REL;
                        s_cnt <= '0;
                    end else if (s_cnt == CNT_LAST) begin
                        state <= HELD;
                        s_cnt <= '0;
                        dSnew <= 1'b1;
                        dInew <= d_stable;
`ifdef BIT_STEP_COUNT_EN
                        stepCount <= stepCount + 8'd1;
`endif
                    end else begin
                        s_cnt <= s_cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!s_s2) begin
                        state <= REL_WAIT;
                        s_cnt <= CNT_ONE;
                    end else begin
                        s_cnt <= '0;
                    end
                end
                REL_WAIT: begin
                    if (s_s2) begin
                        state <= HELD;
                        s_cnt <= '0;
                    end else if (s_cnt == CNT_LAST) begin
                        state <= REL;
                        s_cnt <= '0;
                    end else begin
                        s_cnt <= s_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= REL;
                    s_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_step_feeder.sv
// tb/tb_bit_step_feeder.sv - self-checking bench for bit_step_feeder (DEB_CYCLES=4)
module tb_bit_step_feeder;
    localparam int DEB = 4;

    logic       clk1 = 1'b0;
    logic       clear_n = 1'b0;
    logic       dIraw = 1'b0;
    logic       stepRaw = 1'b0;
    logic       dInew;
    logic       dSnew;
`ifdef BIT_STEP_COUNT_EN
    logic [7:0] stepCount;
`endif

    bit_step_feeder #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
        .clk1    (clk1),
        .clear_n (clear_n),
        .dIraw   (dIraw),
        .stepRaw (stepRaw)
        ,
        .dInew   (dInew),
        .dSnew   (dSnew)
`ifdef BIT_STEP_COUNT_EN
        ,
        .stepCount (stepCount)
`endif
    );

    always #5 clk1 = ~clk1;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int strobes = 0;
    int last_strobe_cyc = -1;
    logic [7:0] strobe_bits = 8'd0;

    // Reference model: debounced level flips once the last DEB synchronized samples all disagree with it.
    logic q_raw_d[$];
    logic q_raw_s[$];
    logic h_d[$];
    logic h_b[$];
    int   m_n;
    logic m_armed, m_lvl, m_stab, m_dinew, m_dsnew;
    logic [7:0] m_cnt;

    function automatic bit win_all(input logic q[$], input logic v);
        if (q.size() < DEB) return 1'b0;
        for (int i = q.size() - DEB; i < q.size(); i++)
            if (q[i] !== v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        q_raw_d.delete(); q_raw_s.delete(); h_d.delete(); h_b.delete();
        m_n = 0; m_armed = 0; m_lvl = 0; m_stab = 0; m_dinew = 0; m_dsnew = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic d, input logic s);
        logic sd, ss, sb;
        q_raw_d.push_back(d);
        q_raw_s.push_back(s);
        sd = 1'b0;
        ss = 1'b0;
        if (m_n >= 2) begin
            sd = q_raw_d[0];
            ss = q_raw_s[0];
            void'(q_raw_d.pop_front());
            void'(q_raw_s.pop_front());
            if (!ss) m_armed = 1'b1;
        end
        sb = m_armed ? ss : 1'b0;
        h_d.push_back(sd);
        h_b.push_back(sb);
        if (h_d.size() > DEB) void'(h_d.pop_front());
        if (h_b.size() > DEB) void'(h_b.pop_front());
        m_dsnew = 1'b0;
        if (win_all(h_b, ~m_lvl)) begin
            m_lvl = ~m_lvl;
            if (m_lvl) begin
                m_dsnew = 1'b1;
                m_dinew = m_stab;
                m_cnt   = m_cnt + 8'd1;
            end
        end
        if (win_all(h_d, ~m_stab)) m_stab = ~m_stab;
        m_n++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge; drives inputs, clocks once, checks against the model, returns at the next negedge.
    task automatic tick(input logic d, input logic s);
        dIraw = d;
        stepRaw = s;
        @(posedge clk1);
        model_edge(d, s);
        #1;
        check("model_dSnew", {31'd0, dSnew}, {31'd0, m_dsnew});
        check("model_dInew", {31'd0, dInew}, {31'd0, m_dinew});
`ifdef BIT_STEP_COUNT_EN
        check("model_stepCount", {24'd0, stepCount}, {24'd0, m_cnt});
`endif
        if (dSnew === 1'b1) begin
            strobes++;
            strobe_bits = {strobe_bits[6:0], dInew};
            last_strobe_cyc = cyc;
        end
        cyc++;
        @(negedge clk1);
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        #1;
        check("reset_async_dSnew", {31'd0, dSnew}, 32'd0);
        check("reset_async_dInew", {31'd0, dInew}, 32'd0);
        model_reset();
        @(posedge clk1);
        @(negedge clk1);
        check("reset_hold_dSnew", {31'd0, dSnew}, 32'd0);
        check("reset_hold_dInew", {31'd0, dInew}, 32'd0);
`ifdef BIT_STEP_COUNT_EN
        check("reset_hold_stepCount", {24'd0, stepCount}, 32'd0);
`endif
        clear_n = 1'b1;
    endtask

    typedef struct {
        logic d;
        logic s;
        logic e_dinew;
        logic e_dsnew;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int s0, rep_cyc, hold_d, hold_s;
        logic rd, rs;
        for (int i = 0; i < 10; i++)
            tbl[i] = '{d: 1'b1, s: 1'b1, e_dinew: (i >= 5), e_dsnew: (i == 5)};

        model_reset();
        @(negedge clk1);
        check("reset_dSnew", {31'd0, dSnew}, 32'd0);
        check("reset_dInew", {31'd0, dInew}, 32'd0);
        clear_n = 1'b1;

        // Clean press with dIraw=1 settled: one strobe after edge 5
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(tbl[i].d, tbl[i].s);
            check($sformatf("tbl_dSnew[%0d]", i), {31'd0, dSnew}, {31'd0, tbl[i].e_dsnew});
            check($sformatf("tbl_dInew[%0d]", i), {31'd0, dInew}, {31'd0, tbl[i].e_dinew});
        end
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);

        // Short bounces: 3 high / 3 low x5
        s0 = strobes;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
            for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        end
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
        check("bounce_strobes", strobes - s0, 32'd0);

        // Held 50, released 10, pressed again
        s0 = strobes;
        for (int i = 0; i < 50; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        rep_cyc = cyc;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
        check("held_strobes", strobes - s0, 32'd2);
        check("repress_latency", last_strobe_cyc - rep_cyc, 32'd5);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);

        // Data sequence 1,0,1 captured on successive strobes
        s0 = strobes;
        for (int k = 0; k < 3; k++) begin
            rd = (k != 1);
            for (int i = 0; i < 12; i++) tick(rd, 1'b0);
            for (int i = 0; i < 8; i++) tick(rd, 1'b1);
            for (int i = 0; i < 8; i++) tick(rd, 1'b0);
        end
        check("data_seq_strobes", strobes - s0, 32'd3);
        check("data_seq_bits", {29'd0, strobe_bits[2:0]}, 32'd5);

        // Reset during PRESS_WAIT with button held through release of clear_n
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        do_reset();
        s0 = strobes;
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1);
        check("held_thru_reset_strobes", strobes - s0, 32'd0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
        check("after_reset_repress_strobes", strobes - s0, 32'd1);
        check("after_reset_repress_dInew", {31'd0, dInew}, 32'd1);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);

        // Randomized bouncy stimulus against the model
        hold_d = 0;
        hold_s = 0;
        rd = 1'b0;
        rs = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (hold_d == 0) begin rd = $urandom_range(0, 1); hold_d = $urandom_range(1, 12); end
            if (hold_s == 0) begin rs = $urandom_range(0, 1); hold_s = $urandom_range(1, 12); end
            hold_d--;
            hold_s--;
            if ($urandom_range(0, 499) == 0) do_reset();
            tick(rd, rs);
        end

`ifdef BIT_STEP_COUNT_EN
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
        for (int p = 0; p < 257; p++) begin
            for (int i = 0; i < 7; i++) tick(1'b0, 1'b1);
            for (int i = 0; i < 7; i++) tick(1'b0, 1'b0);
        end
        check("count_257_wrap", {24'd0, stepCount}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
